// File: rtl/phys_reg_allocator.sv
// Physical-register free pool: in-order multi-lane allocation, multi-port retirement
// frees, bulk flush return, registered free count / low-water flag, sticky illegal-free error.

module pra_lane #(
   parameter int PHYS_REGS = 32,
   parameter int PR_ADDR_W = 5,
   parameter int CNT_W     = 6
) (
   input  logic                 req,
   input  logic                 block,
   input  logic [CNT_W-1:0]     rank,
   input  logic [CNT_W-1:0]     free_count,
   input  logic [PHYS_REGS-1:0] free_pool,
   output logic                 gnt,
   output logic [PR_ADDR_W-1:0] addr
);
   logic [CNT_W-1:0] seen;

   // rank is this lane's 1-based position among requesting lanes, so it
   // selects the rank-th lowest free register.
   always_comb begin
      gnt  = req && !block && (rank <= free_count);
      addr = '0;
      seen = '0;
      for (int b = 0; b < PHYS_REGS; b++) begin
         if (free_pool[b]) begin
            seen = seen + CNT_W'(1);
            if (seen == rank) addr = PR_ADDR_W'(b);
         end
      end
   end
endmodule

module phys_reg_allocator #(
   parameter int PHYS_REGS  = 32,
   parameter int PR_ADDR_W  = 5,
   parameter int RESERVED   = 2,
   parameter int LANES      = 3,
   parameter int FREE_PORTS = 2,
   parameter int CNT_W      = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [LANES-1:0]                alloc_req,
   output logic [LANES-1:0]                alloc_gnt,
   output logic [LANES*PR_ADDR_W-1:0]      alloc_addr,
   input  logic [FREE_PORTS-1:0]           free_valid,
   input  logic [FREE_PORTS*PR_ADDR_W-1:0] free_addr,
   input  logic                            flush,
   input  logic [PHYS_REGS-1:0]            flush_mask,
   output logic [CNT_W-1:0]                free_count,
   output logic                            pool_low,
   output logic                            err
);
   function automatic logic [PHYS_REGS-1:0] res_mask_f();
      logic [PHYS_REGS-1:0] m;
      m = '0;
      for (int b = 0; b < PHYS_REGS; b++) m[b] = (b < RESERVED);
      return m;
   endfunction

   localparam logic [PHYS_REGS-1:0] RES_MASK = res_mask_f();

   logic [PHYS_REGS-1:0]            free_pool;
   logic [PHYS_REGS-1:0]            pool_nx;
   logic [PHYS_REGS-1:0]            freed;
   logic [CNT_W-1:0]                cnt_nx;
   logic                            err_nx;
   logic [PR_ADDR_W-1:0]            fa;
   logic [CNT_W-1:0]                acc;
   logic [LANES-1:0][CNT_W-1:0]     rank;
   logic [LANES-1:0][PR_ADDR_W-1:0] lane_addr;

   always_comb begin
      acc  = '0;
      rank = '0;
      for (int i = 0; i < LANES; i++) begin
         if (alloc_req[i]) acc = acc + CNT_W'(1);
         rank[i] = acc;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      pra_lane #(
         .PHYS_REGS (PHYS_REGS),
         .PR_ADDR_W (PR_ADDR_W),
         .CNT_W     (CNT_W)
      ) u_lane (
         .req        (alloc_req[g]),
         .block      (rst || flush),
         .rank       (rank[g]),
         .free_count (free_count),
         .free_pool  (free_pool),
         .gnt        (alloc_gnt[g]),
         .addr       (lane_addr[g])
      );
      assign alloc_addr[g*PR_ADDR_W +: PR_ADDR_W] = lane_addr[g];
   end

   // Legality is judged against the current pool, so a reg granted this cycle
   // cannot be freed in the same cycle, and a second port hitting the same reg
   // is caught through the freed mask.
   always_comb begin
      pool_nx = free_pool;
      freed   = '0;
      err_nx  = err;
      fa      = '0;
      for (int i = 0; i < LANES; i++)
         for (int b = 0; b < PHYS_REGS; b++)
            if (alloc_gnt[i] && (int'(lane_addr[i]) == b)) pool_nx[b] = 1'b0;
      for (int j = 0; j < FREE_PORTS; j++) begin
         fa = free_addr[j*PR_ADDR_W +: PR_ADDR_W];
         if (free_valid[j]) begin
            if (int'(fa) >= PHYS_REGS) err_nx = 1'b1;
            for (int b = 0; b < PHYS_REGS; b++) begin
               if (int'(fa) == b) begin
                  if (RES_MASK[b] || free_pool[b] || freed[b]) err_nx = 1'b1;
                  else freed[b] = 1'b1;
               end
            end
         end
      end
      pool_nx = pool_nx | freed;
      if (flush) pool_nx = pool_nx | (flush_mask & ~RES_MASK);
      cnt_nx = '0;
      for (int b = 0; b < PHYS_REGS; b++) cnt_nx = cnt_nx + CNT_W'(pool_nx[b]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         free_pool  <= ~RES_MASK;
         free_count <= CNT_W'(PHYS_REGS - RESERVED);
         pool_low   <= 1'b0;
         err        <= 1'b0;
      end else begin
         free_pool  <= pool_nx;
         free_count <= cnt_nx;
         pool_low   <= (cnt_nx < CNT_W'(LANES));
         err        <= err_nx;
      end
   end
endmodule
